// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button input stage of the Simon datapath.
package btn_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_t;

    localparam int unsigned NUM_BTNS = 4;
    localparam int unsigned IDX_W    = 2;

    // Lowest set index wins, so button 0 has the highest priority.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_BTNS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [NUM_BTNS-1:0] v);
        return (v != '0) && ((v & (v - NUM_BTNS'(1))) == '0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser followed by a saturating-free debounce counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // This sample is the last of DEBOUNCE_CYCLES consecutive differing ones.
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced button front end: per-button debounce, press FSM, latched index and strobes.
// Define BTN_MULTI_REJECT_EN to ignore presses while more than one button is stable-high.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btns,
    output logic [IDX_W-1:0]    num,
    output logic                pressed,
    output logic                press_pulse,
    output logic                release_pulse
);

    logic [NUM_BTNS-1:0] stable;
    logic                accept;
    btn_state_t          state;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .btn   (btns[i]),
            .stable(stable[i])
        );
    end

    always_comb begin
`ifdef BTN_MULTI_REJECT_EN
        accept = is_single(stable);
`else
        accept = (stable != '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            num           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= HELD;
                        num         <= lowest_set(stable);
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                    end
                end
                HELD: begin
                    // Leaving through IDLE guarantees a gap cycle before the next press.
                    if (stable == '0) begin
                        state         <= IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES = 4.
module tb_btn_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] btns;
    logic [1:0] num;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btns         (btns),
        .num          (num),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int npress, nrel, pedge, redge;
    logic [1:0] pnum;
    logic rel_pressed;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a bit's stable level flips once the last D synchronised
    // samples all disagree with it; the press/hold rules act on the stable vector.
    logic [3:0] m_sync1, m_s, m_stable;
    logic [3:0] m_hist [0:D-2];
    logic [1:0] m_num;
    logic       m_pressed, m_pp, m_rp;

    function automatic logic [3:0] window_flips();
        logic [3:0] f;
        f = m_s ^ m_stable;
        for (int k = 0; k < D - 1; k++) f &= m_hist[k] ^ m_stable;
        return f;
    endfunction

    function automatic logic model_take(input logic [3:0] v);
`ifdef BTN_MULTI_REJECT_EN
        return $countones(v) == 1;
`else
        return v != 4'b0000;
`endif
    endfunction

    function automatic logic [1:0] model_first(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_sync1 <= '0; m_s <= '0; m_stable <= '0;
            for (int k = 0; k < D - 1; k++) m_hist[k] <= '0;
            m_num <= '0; m_pressed <= 1'b0; m_pp <= 1'b0; m_rp <= 1'b0;
        end else begin
            m_sync1  <= btns;
            m_s      <= m_sync1;
            m_hist[0] <= m_s;
            for (int k = 1; k < D - 1; k++) m_hist[k] <= m_hist[k-1];
            m_stable <= m_stable ^ window_flips();
            m_pp <= 1'b0;
            m_rp <= 1'b0;
            if (!m_pressed && model_take(m_stable)) begin
                m_pressed <= 1'b1; m_num <= model_first(m_stable); m_pp <= 1'b1;
            end else if (m_pressed && m_stable == 4'b0000) begin
                m_pressed <= 1'b0; m_rp <= 1'b1;
            end
        end
    end

    // Advance one clock and note pulses relative to the scenario's edge 0.
    task automatic tick();
        @(negedge clk);
        if (press_pulse === 1'b1) begin npress++; pedge = cyc - base; pnum = num; end
        if (release_pulse === 1'b1) begin nrel++; redge = cyc - base; rel_pressed = pressed; end
    endtask

    task automatic start_scenario();
        npress = 0; nrel = 0; pedge = -1; redge = -1; pnum = 2'd0; rel_pressed = 1'b1;
        base = cyc + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btns  = 4'($urandom);
        repeat (3) tick();
        checks++; if (num !== 2'd0) begin errors++; $display("FAIL reset_num got=%b want=00", num); end
        checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got=%b want=0", pressed); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_press_pulse got=%b want=0", press_pulse); end
        checks++; if (release_pulse !== 1'b0) begin errors++; $display("FAIL reset_release_pulse got=%b want=0", release_pulse); end
        reset = 1'b0;
        btns  = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL reset_idle c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
        end
    endtask

    task automatic test_clean_press();
        start_scenario();
        for (int c = 0; c < 34; c++) begin
            btns = (c < 20) ? 4'b0100 : 4'b0000;
            tick();
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL clean_model c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
        end
        checks++; if (npress !== 1 || pedge !== 6 || pnum !== 2'd2) begin errors++;
            $display("FAIL clean_press got n=%0d edge=%0d num=%0d want n=1 edge=6 num=2", npress, pedge, pnum); end
        checks++; if (nrel !== 1 || redge !== 26) begin errors++;
            $display("FAIL clean_release got n=%0d edge=%0d want n=1 edge=26", nrel, redge); end
        checks++; if (num !== 2'd2) begin errors++; $display("FAIL clean_num_hold got=%0d want=2", num); end
    endtask

    task automatic test_bounce();
        logic b;
        start_scenario();
        for (int c = 0; c < 42; c++) begin
            b = (c < 3) || (c >= 4 && c < 7) || (c >= 8 && c < 28);
            btns = {2'b00, b, 1'b0};
            tick();
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL bounce_model c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
        end
        checks++; if (npress !== 1 || pedge !== 14 || pnum !== 2'd1) begin errors++;
            $display("FAIL bounce_press got n=%0d edge=%0d num=%0d want n=1 edge=14 num=1", npress, pedge, pnum); end
    endtask

    task automatic test_second_button();
        start_scenario();
        for (int c = 0; c < 50; c++) begin
            btns = (c < 12) ? 4'b1000 : (c < 24) ? 4'b1001 : (c < 36) ? 4'b0001 : 4'b0000;
            tick();
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL second_model c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
        end
        checks++; if (npress !== 1 || pedge !== 6 || pnum !== 2'd3) begin errors++;
            $display("FAIL second_press got n=%0d edge=%0d num=%0d want n=1 edge=6 num=3", npress, pedge, pnum); end
        checks++; if (nrel !== 1 || redge !== 42 || num !== 2'd3) begin errors++;
            $display("FAIL second_release got n=%0d edge=%0d num=%0d want n=1 edge=42 num=3", nrel, redge, num); end
    endtask

    task automatic test_simultaneous();
        start_scenario();
        for (int c = 0; c < 38; c++) begin
            btns = (c < 12) ? 4'b1010 : (c < 24) ? 4'b0010 : 4'b0000;
            tick();
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL simul_model c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
        end
`ifdef BTN_MULTI_REJECT_EN
        checks++; if (npress !== 1 || pedge !== 18 || pnum !== 2'd1) begin errors++;
            $display("FAIL simul_press got n=%0d edge=%0d num=%0d want n=1 edge=18 num=1", npress, pedge, pnum); end
`else
        checks++; if (npress !== 1 || pedge !== 6 || pnum !== 2'd1) begin errors++;
            $display("FAIL simul_press got n=%0d edge=%0d num=%0d want n=1 edge=6 num=1", npress, pedge, pnum); end
`endif
        checks++; if (nrel !== 1 || redge !== 30) begin errors++;
            $display("FAIL simul_release got n=%0d edge=%0d want n=1 edge=30", nrel, redge); end
    endtask

    task automatic test_reset_mid_press();
        start_scenario();
        for (int c = 0; c < 45; c++) begin
            btns  = (c < 31) ? 4'b0100 : 4'b0000;
            reset = (c == 12);
            tick();
            if (c == 12) begin
                checks++;
                if ({num, pressed, press_pulse, release_pulse} !== 5'b0) begin errors++;
                    $display("FAIL midreset_clear got=%b want=00000", {num, pressed, press_pulse, release_pulse}); end
            end
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL midreset_model c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
        end
        reset = 1'b0;
        checks++; if (npress !== 2 || pedge !== 19 || pnum !== 2'd2) begin errors++;
            $display("FAIL midreset_repress got n=%0d edge=%0d num=%0d want n=2 edge=19 num=2", npress, pedge, pnum); end
        checks++; if (nrel !== 1 || redge !== 37) begin errors++;
            $display("FAIL midreset_release got n=%0d edge=%0d want n=1 edge=37", nrel, redge); end
    endtask

    // Button 1 goes down one sample after button 0 lifts, so its stable bit rises
    // on the very edge the controller first sees an all-released vector.
    task automatic test_back_to_back();
        start_scenario();
        for (int c = 0; c < 41; c++) begin
            btns = (c < 12) ? 4'b0001 : (c == 12) ? 4'b0000 : (c < 27) ? 4'b0010 : 4'b0000;
            tick();
            checks++;
            if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                errors++;
                $display("FAIL b2b_model c=%0d got=%b want=%b", c,
                         {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
            end
            if (c == 18) begin
                checks++;
                if (release_pulse !== 1'b1 || pressed !== 1'b0 || press_pulse !== 1'b0) begin errors++;
                    $display("FAIL b2b_gap got rp=%b pressed=%b pp=%b want rp=1 pressed=0 pp=0",
                             release_pulse, pressed, press_pulse); end
            end
        end
        checks++; if (npress !== 2 || pedge !== 19 || pnum !== 2'd1) begin errors++;
            $display("FAIL b2b_press got n=%0d edge=%0d num=%0d want n=2 edge=19 num=1", npress, pedge, pnum); end
        checks++; if (nrel !== 2 || redge !== 33 || rel_pressed !== 1'b0) begin errors++;
            $display("FAIL b2b_release got n=%0d edge=%0d want n=2 edge=33", nrel, redge); end
    endtask

    task automatic test_random();
        int sel, len;
        start_scenario();
        for (int seg = 0; seg < 70; seg++) begin
            sel = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 9));
            if (sel < 3) btns = 4'b0000;
            else if (sel < 6) btns = 4'b0001 << $urandom_range(0, 3);
            else if (sel == 6) btns = 4'($urandom);
            for (int c = 0; c < len; c++) begin
                reset = ($urandom_range(0, 39) == 0);
                tick();
                checks++;
                if ({num, pressed, press_pulse, release_pulse} !== {m_num, m_pressed, m_pp, m_rp}) begin
                    errors++;
                    $display("FAIL random_model seg=%0d got=%b want=%b", seg,
                             {num, pressed, press_pulse, release_pulse}, {m_num, m_pressed, m_pp, m_rp});
                end
                checks++;
                if ((press_pulse & release_pulse) !== 1'b0) begin errors++;
                    $display("FAIL random_pulse_overlap got pp=%b rp=%b want not both", press_pulse, release_pulse); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        btns  = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_second_button();
        test_simultaneous();
        test_reset_mid_press();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
